llc_tag_plru_array: RTL and testbench

//  Parametrised LLC tag/state store: N_WAY-way, NUM_SETS-set array of line_st with a tree-PLRU per set.

---
 rtl/llc_tag_plru_array_pkg.sv | 24 ++
 rtl/llc_tag_plru_array_if.sv | 35 +++
 rtl/llc_tag_plru_array_plru.sv | 34 +++
 rtl/llc_tag_plru_array.sv | 206 ++++++++++++++++++++
 tb/tb_llc_tag_plru_array.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/llc_tag_plru_array_pkg.sv
// Shared types for the LLC tag/state array: request opcodes, MESI states, FSM states.
package llc_tag_plru_array_pkg;

  typedef enum logic [1:0] {
    OP_RD      = 2'b00,
    OP_WR      = 2'b01,
    OP_FILL    = 2'b10,
    OP_SNP_INV = 2'b11
  } llc_op_e;

  typedef enum logic [1:0] {
    MESI_I = 2'b00,
    MESI_S = 2'b01,
    MESI_E = 2'b10,
    MESI_M = 2'b11
  } mesi_e;

  typedef enum logic [1:0] {
    ST_INIT = 2'b00,
    ST_IDLE = 2'b01,
    ST_RESP = 2'b10
  } llc_state_e;

endpackage

// File: rtl/llc_tag_plru_array_if.sv
// Request/response channel between the request sequencer (master) and the tag array (slave).
interface llc_tag_plru_array_if
  import llc_tag_plru_array_pkg::*;
#(
  parameter int ADDR_SIZE = 32,
  parameter int WAY_W     = 4,
  parameter int TAG_SIZE  = 12
);
  logic                 req_valid;
  logic                 req_ready;
  llc_op_e              req_op;
  logic [ADDR_SIZE-1:0] req_addr;
  mesi_e                req_mesi;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic                 rsp_hit;
  logic [WAY_W-1:0]     rsp_way;
  mesi_e                rsp_mesi;
  logic                 rsp_dirty;
  logic                 rsp_evict;
  logic [TAG_SIZE-1:0]  rsp_evict_tag;
  logic                 rsp_evict_dirty;

  modport master (
    output req_valid, req_op, req_addr, req_mesi, rsp_ready,
    input  req_ready, rsp_valid, rsp_hit, rsp_way, rsp_mesi, rsp_dirty,
           rsp_evict, rsp_evict_tag, rsp_evict_dirty
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_mesi, rsp_ready,
    output req_ready, rsp_valid, rsp_hit, rsp_way, rsp_mesi, rsp_dirty,
           rsp_evict, rsp_evict_tag, rsp_evict_dirty
  );
endinterface

// File: rtl/llc_tag_plru_array_plru.sv
// Combinational tree-PLRU for one set: touch update and victim selection.
module llc_plru_tree #(
  parameter int N_WAY = 16,
  localparam int WAY_W = $clog2(N_WAY),
  localparam int PLRU_BITS = N_WAY - 1
) (
  input  logic [PLRU_BITS-1:0] i_plru,
  input  logic [WAY_W-1:0]     i_touch_way,
  output logic [PLRU_BITS-1:0] o_plru,
  output logic [WAY_W-1:0]     o_victim_way
);
  logic [N_WAY-1:0] w_plru_pad;
  logic [WAY_W-1:0] w_node;

  assign w_plru_pad = {1'b0, i_plru};

  // A node is on the touch path when its position in its level equals the way's prefix
  for (genvar gi = 0; gi < PLRU_BITS; gi++) begin : g_node
    localparam int LVL = $clog2(gi + 2) - 1;
    localparam int POS = gi + 1 - (1 << LVL);
    logic [WAY_W-1:0] w_prefix;
    assign w_prefix   = i_touch_way >> (WAY_W - LVL);
    assign o_plru[gi] = (w_prefix == WAY_W'(POS)) ? ~i_touch_way[WAY_W-1-LVL] : i_plru[gi];
  end

  always_comb begin
    w_node       = '0;
    o_victim_way = '0;
    for (int l = 0; l < WAY_W; l++) begin
      o_victim_way[WAY_W-1-l] = w_plru_pad[w_node];
      w_node = (w_node << 1) + WAY_W'(1) + WAY_W'(w_plru_pad[w_node]);
    end
  end
endmodule

// File: rtl/llc_tag_plru_array.sv
// LLC tag/state store: per-set tree-PLRU, one request in flight, post-reset clear sweep, stats.
module llc_tag_plru_array
  import llc_tag_plru_array_pkg::*;
#(
  parameter int CACHE_SIZE = 16 * 1024 * 1024,
  parameter int ADDR_SIZE  = 32,
  parameter int LINE_SIZE  = 64,
  parameter int N_WAY      = 16,
  parameter int CNT_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  llc_tag_plru_array_if.slave  bus,
  input  logic                 i_stats_clr,
  output logic [CNT_W-1:0]     o_hit_cnt,
  output logic [CNT_W-1:0]     o_miss_cnt,
  output logic [CNT_W-1:0]     o_evict_cnt
);
  localparam int NUM_SETS    = CACHE_SIZE / (LINE_SIZE * N_WAY);
  localparam int OFFSET_SIZE = $clog2(LINE_SIZE);
  localparam int INDEX_SIZE  = $clog2(NUM_SETS);
  localparam int TAG_SIZE    = ADDR_SIZE - INDEX_SIZE - OFFSET_SIZE;
  localparam int WAY_W       = $clog2(N_WAY);
  localparam int PLRU_BITS   = N_WAY - 1;

  typedef struct packed {
    logic                valid;
    logic                dirty;
    mesi_e               mesi;
    logic [TAG_SIZE-1:0] tag;
  } line_st;

  typedef struct packed {
    logic [PLRU_BITS-1:0]   plru;
    line_st [N_WAY-1:0]     ways;
  } set_st;

  typedef struct packed {
    logic                hit;
    logic [WAY_W-1:0]    way;
    mesi_e               mesi;
    logic                dirty;
    logic                evict;
    logic [TAG_SIZE-1:0] evict_tag;
    logic                evict_dirty;
  } rsp_st;

  llc_state_e            r_state, w_state_next;
  logic [INDEX_SIZE-1:0] r_ptr, w_ptr_next;
  set_st                 r_sets [NUM_SETS];
  rsp_st                 r_rsp, w_rsp;
  set_st                 w_set, w_set_next;
  logic [INDEX_SIZE-1:0] w_idx;
  logic [TAG_SIZE-1:0]   w_tag;
  logic [N_WAY-1:0]      w_hit_vec, w_inv_vec;
  logic [WAY_W-1:0]      w_hit_way, w_inv_way, w_victim_way, w_fill_way, w_touch_way;
  logic [PLRU_BITS-1:0]  w_plru_touched;
  logic                  w_hit, w_any_inv, w_accept, w_wr_en;
  logic [2:0]            w_inc;
  logic                  w_unused_offset;

  assign w_idx           = bus.req_addr[OFFSET_SIZE +: INDEX_SIZE];
  assign w_tag           = bus.req_addr[ADDR_SIZE-1 -: TAG_SIZE];
  assign w_unused_offset = ^bus.req_addr[OFFSET_SIZE-1:0];
  assign w_set           = r_sets[w_idx];
  assign w_accept        = (r_state == ST_IDLE) && bus.req_valid;

  for (genvar gi = 0; gi < N_WAY; gi++) begin : g_way
    assign w_hit_vec[gi] = w_set.ways[gi].valid && (w_set.ways[gi].mesi != MESI_I)
                           && (w_set.ways[gi].tag == w_tag);
    assign w_inv_vec[gi] = !(w_set.ways[gi].valid && (w_set.ways[gi].mesi != MESI_I));
  end

  always_comb begin
    w_hit_way = '0;
    w_inv_way = '0;
    for (int w = N_WAY - 1; w >= 0; w--) begin
      if (w_hit_vec[w]) w_hit_way = WAY_W'(w);
      if (w_inv_vec[w]) w_inv_way = WAY_W'(w);
    end
  end

  assign w_hit       = |w_hit_vec;
  assign w_any_inv   = |w_inv_vec;
  assign w_fill_way  = w_any_inv ? w_inv_way : w_victim_way;
  assign w_touch_way = w_hit ? w_hit_way : w_fill_way;

  llc_plru_tree #(.N_WAY(N_WAY)) u_plru (
    .i_plru       (w_set.plru),
    .i_touch_way  (w_touch_way),
    .o_plru       (w_plru_touched),
    .o_victim_way (w_victim_way)
  );

  always_comb begin
    w_set_next = w_set;
    w_rsp      = '0;
    w_wr_en    = 1'b0;
    w_inc      = '0;
    if (w_hit && (bus.req_op != OP_FILL || bus.req_mesi != MESI_I)) begin
      w_rsp.hit   = 1'b1;
      w_rsp.way   = w_hit_way;
      w_rsp.mesi  = w_set.ways[w_hit_way].mesi;
      w_rsp.dirty = w_set.ways[w_hit_way].dirty;
    end
    case (bus.req_op)
      OP_RD, OP_WR: begin
        if (w_hit) begin
          w_wr_en         = 1'b1;
          w_inc[0]        = 1'b1;
          w_set_next.plru = w_plru_touched;
          if (bus.req_op == OP_WR) begin
            w_set_next.ways[w_hit_way].mesi  = MESI_M;
            w_set_next.ways[w_hit_way].dirty = 1'b1;
          end
        end else begin
          w_inc[1] = 1'b1;
        end
      end
      OP_FILL: begin
        if (bus.req_mesi != MESI_I) begin
          w_wr_en         = 1'b1;
          w_set_next.plru = w_plru_touched;
          if (w_hit) begin
            w_set_next.ways[w_hit_way].mesi = bus.req_mesi;
          end else begin
            w_rsp.way = w_fill_way;
            // Victim is only a live line when no invalid way was available
            if (!w_any_inv) begin
              w_rsp.evict       = 1'b1;
              w_rsp.evict_tag   = w_set.ways[w_fill_way].tag;
              w_rsp.evict_dirty = w_set.ways[w_fill_way].dirty;
              w_inc[2]          = 1'b1;
            end
            w_set_next.ways[w_fill_way] = '{valid: 1'b1, dirty: (bus.req_mesi == MESI_M),
                                            mesi: bus.req_mesi, tag: w_tag};
          end
        end
      end
      default: begin
        if (w_hit) begin
          w_wr_en                    = 1'b1;
          w_set_next.ways[w_hit_way] = '0;
        end
      end
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    case (r_state)
      ST_INIT: begin
        w_ptr_next = r_ptr + 1'b1;
        if (r_ptr == INDEX_SIZE'(NUM_SETS - 1)) begin
          w_state_next = ST_IDLE;
          w_ptr_next   = '0;
        end
      end
      ST_IDLE: if (bus.req_valid) w_state_next = ST_RESP;
      ST_RESP: if (bus.rsp_ready) w_state_next = ST_IDLE;
      default: w_state_next = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
      r_ptr   <= '0;
      r_rsp   <= '0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
      if (w_accept) r_rsp <= w_rsp;
    end
  end

  // Tag storage carries no reset; the INIT sweep is what clears it
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) r_sets[r_ptr] <= '0;
    else if (w_accept && w_wr_en) r_sets[w_idx] <= w_set_next;
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_cnt <= '0;
      else if (i_stats_clr) r_cnt <= '0;
      else if (w_accept && w_inc[gi] && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_hit_cnt   = g_cnt[0].r_cnt;
  assign o_miss_cnt  = g_cnt[1].r_cnt;
  assign o_evict_cnt = g_cnt[2].r_cnt;

  assign bus.req_ready       = (r_state == ST_IDLE);
  assign bus.rsp_valid       = (r_state == ST_RESP);
  assign bus.rsp_hit         = r_rsp.hit;
  assign bus.rsp_way         = r_rsp.way;
  assign bus.rsp_mesi        = r_rsp.mesi;
  assign bus.rsp_dirty       = r_rsp.dirty;
  assign bus.rsp_evict       = r_rsp.evict;
  assign bus.rsp_evict_tag   = r_rsp.evict_tag;
  assign bus.rsp_evict_dirty = r_rsp.evict_dirty;
endmodule

// File: tb/tb_llc_tag_plru_array.sv
// Bench for llc_tag_plru_array: directed scenarios plus random traffic against a set/way/tree model.
module tb_llc_tag_plru_array;
  import llc_tag_plru_array_pkg::*;

  localparam int N_WAY = 4, CACHE_SIZE = 1024, CNT_W = 2, ADDR_SIZE = 32, LINE_SIZE = 64;
  localparam int NUM_SETS = 4, WAY_W = 2, TAG_SIZE = 24, CNT_MAX = 3;
  localparam int MI = 0, MS = 1, ME = 2, MM = 3;
  localparam int RD = 0, WR = 1, FILL = 2, SNP = 3;

  typedef struct {
    bit hit; int way; int mesi; bit dirty; bit evict; logic [23:0] etag; bit edirty;
  } rsp_t;

  logic clk = 0, rst_n = 0, stats_clr = 0;
  logic [CNT_W-1:0] hit_cnt, miss_cnt, evict_cnt;

  llc_tag_plru_array_if #(.ADDR_SIZE(ADDR_SIZE), .WAY_W(WAY_W), .TAG_SIZE(TAG_SIZE)) bus ();

  llc_tag_plru_array #(
    .CACHE_SIZE(CACHE_SIZE), .ADDR_SIZE(ADDR_SIZE), .LINE_SIZE(LINE_SIZE),
    .N_WAY(N_WAY), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .i_stats_clr(stats_clr),
    .o_hit_cnt(hit_cnt), .o_miss_cnt(miss_cnt), .o_evict_cnt(evict_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0, txn_no = 0;
  bit m_valid [NUM_SETS][N_WAY];
  logic [23:0] m_tag [NUM_SETS][N_WAY];
  int m_mesi [NUM_SETS][N_WAY];
  bit m_dirty [NUM_SETS][N_WAY];
  bit m_tree [NUM_SETS][N_WAY-1];
  int m_cnt [3];
  rsp_t exp_cur;
  bit exp_pending = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NUM_SETS; s++) begin
      for (int w = 0; w < N_WAY; w++) begin
        m_valid[s][w] = 0; m_tag[s][w] = '0; m_mesi[s][w] = MI; m_dirty[s][w] = 0;
      end
      for (int n = 0; n < N_WAY - 1; n++) m_tree[s][n] = 0;
    end
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
  endtask

  // Range-halving walk: a 0 node sends the victim search to the lower half
  function automatic int plru_victim(input int s);
    int lo = 0, hi = N_WAY, n = 0, mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (!m_tree[s][n]) begin hi = mid; n = 2 * n + 1; end
      else begin lo = mid; n = 2 * n + 2; end
    end
    return lo;
  endfunction

  task automatic plru_touch(input int s, input int way);
    int lo = 0, hi = N_WAY, n = 0, mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (way < mid) begin m_tree[s][n] = 1; hi = mid; n = 2 * n + 1; end
      else begin m_tree[s][n] = 0; lo = mid; n = 2 * n + 2; end
    end
  endtask

  task automatic model_apply(input int op, input int s, input logic [23:0] tag, input int mesi,
                             input bit clr, output rsp_t e);
    int hw = -1, v = -1;
    bit inc[3] = '{0, 0, 0};
    e = '{default: 0};
    for (int w = 0; w < N_WAY; w++)
      if (hw < 0 && m_valid[s][w] && m_mesi[s][w] != MI && m_tag[s][w] == tag) hw = w;
    if (hw >= 0 && (op != FILL || mesi != MI)) begin
      e.hit = 1; e.way = hw; e.mesi = m_mesi[s][hw]; e.dirty = m_dirty[s][hw];
    end
    case (op)
      RD, WR: begin
        if (hw >= 0) begin
          inc[0] = 1;
          if (op == WR) begin m_mesi[s][hw] = MM; m_dirty[s][hw] = 1; end
          plru_touch(s, hw);
        end else inc[1] = 1;
      end
      FILL: begin
        if (mesi != MI) begin
          if (hw >= 0) begin
            m_mesi[s][hw] = mesi;
            plru_touch(s, hw);
          end else begin
            for (int w = 0; w < N_WAY; w++)
              if (v < 0 && !(m_valid[s][w] && m_mesi[s][w] != MI)) v = w;
            if (v < 0) begin
              v = plru_victim(s);
              e.evict = 1; e.etag = m_tag[s][v]; e.edirty = m_dirty[s][v]; inc[2] = 1;
            end
            e.way = v;
            m_valid[s][v] = 1; m_tag[s][v] = tag; m_mesi[s][v] = mesi; m_dirty[s][v] = (mesi == MM);
            plru_touch(s, v);
          end
        end
      end
      default: begin
        if (hw >= 0) begin m_valid[s][hw] = 0; m_mesi[s][hw] = MI; m_dirty[s][hw] = 0; end
      end
    endcase
    for (int i = 0; i < 3; i++) begin
      if (clr) m_cnt[i] = 0;
      else if (inc[i] && m_cnt[i] < CNT_MAX) m_cnt[i]++;
    end
  endtask

  function automatic rsp_t capture();
    rsp_t a;
    a.hit = bus.rsp_hit; a.way = int'(bus.rsp_way); a.mesi = int'(bus.rsp_mesi);
    a.dirty = bus.rsp_dirty; a.evict = bus.rsp_evict; a.etag = bus.rsp_evict_tag;
    a.edirty = bus.rsp_evict_dirty;
    return a;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      chk("hit_cnt", hit_cnt, m_cnt[0]);
      chk("miss_cnt", miss_cnt, m_cnt[1]);
      chk("evict_cnt", evict_cnt, m_cnt[2]);
      if (bus.rsp_valid) begin
        chk("rsp_valid_unexpected", bus.rsp_valid, exp_pending);
        if (exp_pending) begin
          chk("rsp_hit", bus.rsp_hit, exp_cur.hit);
          chk("rsp_way", bus.rsp_way, exp_cur.way);
          chk("rsp_mesi", bus.rsp_mesi, exp_cur.mesi);
          chk("rsp_dirty", bus.rsp_dirty, exp_cur.dirty);
          chk("rsp_evict", bus.rsp_evict, exp_cur.evict);
          chk("rsp_evict_tag", bus.rsp_evict_tag, exp_cur.etag);
          chk("rsp_evict_dirty", bus.rsp_evict_dirty, exp_cur.edirty);
          chk("req_ready_in_resp", bus.req_ready, 0);
        end
      end
    end
  end

  task automatic finish_rsp(input int hold);
    repeat (hold) begin @(posedge clk); #1; end
    bus.rsp_ready = 1;
    @(posedge clk); #1;
    bus.rsp_ready = 0;
    exp_pending = 0;
  endtask

  task automatic drive_req(input int op, input int s, input logic [23:0] tag, input int mesi);
    bus.req_valid = 1;
    bus.req_op    = llc_op_e'(op);
    bus.req_addr  = {tag, 2'(s), 6'($urandom_range(0, 63))};
    bus.req_mesi  = mesi_e'(mesi);
  endtask

  task automatic do_req(input int op, input int s, input logic [23:0] tag, input int mesi,
                        input bit clr, input int hold, input bit no_finish, output rsp_t act);
    int n = 0;
    act = '{default: 0};
    drive_req(op, s, tag, mesi);
    while (!bus.req_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!bus.req_ready) begin
      chk("req_ready_timeout", bus.req_ready, 1);
      bus.req_valid = 0;
      return;
    end
    stats_clr = clr;
    @(posedge clk); #1;
    stats_clr = 0;
    bus.req_valid = 0;
    model_apply(op, s, tag, mesi, clr, exp_cur);
    exp_pending = 1;
    chk("rsp_latency", bus.rsp_valid, 1);
    act = capture();
    txn_no++;
    $display("txn %0d op=%s set=%0d tag=%h mesi=%0d clr=%0b -> hit=%0b way=%0d pm=%0d pd=%0b ev=%0b etag=%h cnt=%0d/%0d/%0d",
             txn_no, bus.req_op.name(), s, tag, mesi, clr, act.hit, act.way, act.mesi, act.dirty,
             act.evict, act.etag, hit_cnt, miss_cnt, evict_cnt);
    if (!no_finish) finish_rsp(hold);
  endtask

  task automatic wait_init(input string name);
    int n = 0;
    while (!bus.req_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk(name, n, 4);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rsp_t a;
    logic [23:0] ta = 24'hA, tb = 24'hB, tc = 24'hC, td = 24'hD, tf = 24'hF, tz = 24'h77;
    bus.req_valid = 0; bus.req_op = OP_RD; bus.req_addr = '0; bus.req_mesi = MESI_I;
    bus.rsp_ready = 0;
    model_reset();

    // 1: reset values, sweep length, first miss
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_hit", bus.rsp_hit, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    rst_n = 1;
    wait_init("init_cycles");
    do_req(RD, 3, 24'h55, MI, 0, 0, 0, a);
    chk("t1_rd_hit", a.hit, 0);
    chk("t1_miss_cnt", miss_cnt, 1);

    // 2: fills into empty ways, then PLRU victims
    do_req(FILL, 0, ta, ME, 0, 0, 0, a); chk("t2_way_a", a.way, 0); chk("t2_ev_a", a.evict, 0);
    do_req(FILL, 0, tb, ME, 0, 0, 0, a); chk("t2_way_b", a.way, 1);
    do_req(FILL, 0, tc, ME, 0, 0, 0, a); chk("t2_way_c", a.way, 2);
    do_req(FILL, 0, td, ME, 0, 0, 0, a); chk("t2_way_d", a.way, 3); chk("t2_ev_d", a.evict, 0);
    do_req(FILL, 0, tf, ME, 0, 0, 0, a);
    chk("t2_f_way", a.way, 0); chk("t2_f_evict", a.evict, 1); chk("t2_f_etag", a.etag, ta);
    do_req(FILL, 1, ta, ME, 0, 0, 0, a);
    do_req(FILL, 1, tb, ME, 0, 0, 0, a);
    do_req(FILL, 1, tc, ME, 0, 0, 0, a);
    do_req(FILL, 1, td, ME, 0, 0, 0, a);
    do_req(RD, 1, ta, MI, 0, 0, 0, a); chk("t2_rd_a_hit", a.hit, 1); chk("t2_rd_a_way", a.way, 0);
    do_req(FILL, 1, tf, ME, 0, 0, 0, a);
    chk("t2_f2_way", a.way, 2); chk("t2_f2_etag", a.etag, tc); chk("t2_f2_evict", a.evict, 1);

    // 3: write-hit, snoop-invalidate, then miss
    do_req(FILL, 2, ta, ME, 0, 0, 0, a);
    do_req(WR, 2, ta, MI, 0, 0, 0, a); chk("t3_wr_hit", a.hit, 1); chk("t3_wr_mesi", a.mesi, ME);
    do_req(SNP, 2, ta, MI, 0, 0, 0, a);
    chk("t3_snp_mesi", a.mesi, MM); chk("t3_snp_dirty", a.dirty, 1);
    do_req(RD, 2, ta, MI, 0, 0, 0, a); chk("t3_rd_hit", a.hit, 0);

    // 4: response backpressure with a pending request held on the bus
    do_req(RD, 0, tb, MI, 0, 0, 1, a);
    drive_req(RD, 0, tc, MI);
    repeat (3) begin
      @(posedge clk); #1;
      chk("t4_valid_held", bus.rsp_valid, 1);
      chk("t4_hit_held", bus.rsp_hit, 1);
      chk("t4_way_held", bus.rsp_way, 1);
      chk("t4_ready_low", bus.req_ready, 0);
    end
    bus.rsp_ready = 1;
    @(posedge clk); #1;
    bus.rsp_ready = 0;
    exp_pending = 0;
    chk("t4_rsp_dropped", bus.rsp_valid, 0);
    chk("t4_ready_back", bus.req_ready, 1);
    @(posedge clk); #1;
    bus.req_valid = 0;
    model_apply(RD, 0, tc, MI, 0, exp_cur);
    exp_pending = 1;
    chk("t4_second_valid", bus.rsp_valid, 1);
    chk("t4_second_way", bus.rsp_way, 2);
    finish_rsp(0);

    // 5: counter saturation and clear priority
    stats_clr = 1;
    @(posedge clk); #1;
    stats_clr = 0;
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    repeat (5) do_req(RD, 3, tz, MI, 0, 0, 0, a);
    chk("t5_miss_sat", miss_cnt, 3);
    do_req(RD, 0, tb, MI, 1, 0, 0, a);
    chk("t5_clr_hit", hit_cnt, 0); chk("t5_clr_miss", miss_cnt, 0); chk("t5_clr_rsp_hit", a.hit, 1);

    // 6: reset during a response
    do_req(RD, 1, tb, MI, 0, 0, 1, a);
    #2;
    rst_n = 0;
    #1;
    chk("t6_rsp_valid_async", bus.rsp_valid, 0);
    chk("t6_ready_async", bus.req_ready, 0);
    model_reset();
    exp_pending = 0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    wait_init("t6_init_cycles");
    chk("t6_hit_cnt0", hit_cnt, 0);
    for (int s = 0; s < NUM_SETS; s++) begin
      do_req(RD, s, tb, MI, 0, 0, 0, a);
      chk("t6_all_miss", a.hit, 0);
    end

    // random traffic over a small tag pool so hits, evictions and snoops all occur
    for (int t = 0; t < 300; t++) begin
      int r = $urandom_range(0, 9);
      int op = (r < 4) ? FILL : (r < 7) ? RD : (r < 9) ? WR : SNP;
      do_req(op, $urandom_range(0, NUM_SETS - 1), 24'h100 + 24'($urandom_range(0, 5)),
             $urandom_range(0, 3), ($urandom_range(0, 15) == 0), $urandom_range(0, 2), 0, a);
      repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
